// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its neighbours: the redirect decision and
// hazard controls coming in, the instruction-memory read port, and the IF/ID
// register contents plus fault/perf status going out.
interface fetch_stage_if;
  // redirect decision and hazard controls
  logic [2:0]  decision_sel;
  logic        if_id_flush;
  logic        stall;
  logic [31:0] branch_target;
  logic [31:0] jal_target;
  logic [31:0] jalr_target;
  // instruction memory read port (combinational read of imem_addr)
  logic [31:0] instr_in;
  logic [31:0] imem_addr;
  // IF/ID register
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  // status
  logic        fault;
  logic [31:0] fault_pc;
  logic [15:0] redirect_count;

  // the side that drives the fetch stage (decision logic, imem, hazard unit)
  modport master (
    output decision_sel, if_id_flush, stall,
    output branch_target, jal_target, jalr_target,
    output instr_in,
    input  imem_addr, if_id_instr, if_id_pc, if_id_valid,
    input  fault, fault_pc, redirect_count
  );

  // the fetch stage itself
  modport slave (
    input  decision_sel, if_id_flush, stall,
    input  branch_target, jal_target, jalr_target,
    input  instr_in,
    output imem_addr, if_id_instr, if_id_pc, if_id_valid,
    output fault, fault_pc, redirect_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC selection from the
// branch/jump decision, IF/ID pipeline register, sticky misaligned-target
// fault and a saturating taken-redirect counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.slave  bus
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  localparam logic [2:0] SEL_SEQ  = 3'b000;
  localparam logic [2:0] SEL_BR   = 3'b001;
  localparam logic [2:0] SEL_JAL  = 3'b010;
  localparam logic [2:0] SEL_JALR = 3'b011;

  logic [0:0]  state_q,  state_nxt;
  logic [31:0] pc_q,     pc_nxt;
  logic [31:0] instr_q,  instr_nxt;
  logic [31:0] ipc_q,    ipc_nxt;
  logic        vld_q,    vld_nxt;
  logic        fault_q,  fault_nxt;
  logic [31:0] fpc_q,    fpc_nxt;
  logic [15:0] cnt_q,    cnt_nxt;

  logic [31:0] tgt;
  logic        redirect;
  logic        misaligned;

  // Decode the PC source; reserved encodings fall back to sequential fetch.
  always_comb begin
    tgt      = 32'h0;
    redirect = 1'b0;
    case (bus.decision_sel)
      SEL_BR: begin
        tgt      = bus.branch_target;
        redirect = 1'b1;
      end
      SEL_JAL: begin
        tgt      = bus.jal_target;
        redirect = 1'b1;
      end
      SEL_JALR: begin
        // JALR clears bit 0 of the computed target before use
        tgt      = bus.jalr_target & ~32'h1;
        redirect = 1'b1;
      end
      default: begin
        tgt      = 32'h0;
        redirect = 1'b0;
      end
    endcase
    misaligned = redirect && (tgt[1:0] != 2'b00);
  end

  // Next-state for PC, IF/ID, fault capture and redirect counter.
  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    instr_nxt = instr_q;
    ipc_nxt   = ipc_q;
    vld_nxt   = vld_q;
    fault_nxt = fault_q;
    fpc_nxt   = fpc_q;
    cnt_nxt   = cnt_q;

    if (state_q == ST_RUN) begin
      // PC: a bad target freezes fetch; a redirect beats a stall
      if (misaligned) begin
        fault_nxt = 1'b1;
        fpc_nxt   = tgt;
        state_nxt = ST_FAULT;
      end else if (redirect) begin
        pc_nxt = tgt;
      end else if (!bus.stall) begin
        pc_nxt = pc_q + 32'd4;
      end

      // IF/ID: flush (or a faulting redirect) beats stall
      if (bus.if_id_flush || misaligned) begin
        instr_nxt = NOP;
        ipc_nxt   = 32'h0;
        vld_nxt   = 1'b0;
      end else if (!bus.stall) begin
        instr_nxt = bus.instr_in;
        ipc_nxt   = pc_q;
        vld_nxt   = 1'b1;
      end

      // only redirects that actually take effect are counted
      if (redirect && !misaligned && (cnt_q != 16'hFFFF))
        cnt_nxt = cnt_q + 16'd1;
    end else begin
      // faulted: everything frozen except IF/ID, which keeps issuing bubbles
      instr_nxt = NOP;
      ipc_nxt   = 32'h0;
      vld_nxt   = 1'b0;
    end
  end

  // State registers; reset takes effect immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      ipc_q   <= 32'h0;
      vld_q   <= 1'b0;
      fault_q <= 1'b0;
      fpc_q   <= 32'h0;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
      instr_q <= instr_nxt;
      ipc_q   <= ipc_nxt;
      vld_q   <= vld_nxt;
      fault_q <= fault_nxt;
      fpc_q   <= fpc_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc       = ipc_q;
  assign bus.if_id_valid    = vld_q;
  assign bus.fault          = fault_q;
  assign bus.fault_pc       = fpc_q;
  assign bus.redirect_count = cnt_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline: holds the program counter, selects the next PC from the redirect decision produced by the branch/jump decision block, and loads the IF/ID pipeline register. Sits directly downstream of the branch/jump decision logic, consuming its 3-bit PC-source select and its IF/ID flush. Also enforces 4-byte alignment of redirect targets with a sticky fault state, and counts taken redirects for performance monitoring.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP, 32'h0000_0013, instruction word injected into IF/ID on flush, reset or fault.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- decision_sel  in  3  PC source: 000 = PC+4, 001 = branch, 010 = JAL, 011 = JALR, 1xx = reserved, treated as 000.
- if_id_flush  in  1  flush IF/ID at the next edge.
- stall  in  1  hazard-unit stall: hold PC and IF/ID.
- branch_target  in  32  taken-branch target.
- jal_target  in  32  JAL target.
- jalr_target  in  32  JALR target, bit 0 not yet cleared.
- instr_in  in  32  instruction word from instruction memory (combinational read of imem_addr).
- imem_addr  out  32  current PC.
- if_id_instr  out  32  registered instruction.
- if_id_pc  out  32  registered PC of if_id_instr.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fault  out  1  sticky misaligned-target fault.
- fault_pc  out  32  offending target address.
- redirect_count  out  16  saturating count of taken redirects.

## Operation
- FSM states:
  - RUN (reset state).
  - FAULT, entered only from RUN and left only by reset.
- Target selection in RUN: tgt = branch_target / jal_target / (jalr_target & ~32'h1) for 001 / 010 / 011.
- redirect = decision_sel ∈ {001, 010, 011}.
- misaligned = redirect && tgt[1:0] != 2'b00.
- PC update in RUN, priority high to low:
  - misaligned: PC held; fault <= 1; fault_pc <= tgt; state <= FAULT.
  - redirect: PC <= tgt. Redirect wins over stall.
  - stall: PC held.
  - otherwise: PC <= PC + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- IF/ID update in RUN, priority high to low:
  - if_id_flush or misaligned: instr <= NOP, pc <= 0, valid <= 0.
  - stall: hold all three registers.
  - otherwise: instr <= instr_in, pc <= PC, valid <= 1.
- Behaviour in FAULT:
  - PC frozen.
  - IF/ID forced to NOP/0/valid=0 every cycle.
  - All inputs ignored; redirect_count frozen.
- redirect_count increments by 1 on each RUN edge where redirect && !misaligned. It saturates at 16'hFFFF.
- Reset values:
  - imem_addr = RESET_PC.
  - if_id_instr = NOP, if_id_pc = 0, if_id_valid = 0.
  - fault = 0, fault_pc = 0, redirect_count = 0.
  - State = RUN.

## Timing
- All state changes occur on the rising clk edge, except reset.
- Reset assertion clears all registers immediately, independent of clk, including mid-redirect or while in FAULT. First fetch edge is the first rising edge after rst_n deasserts.
- Redirect latency: decision_sel sampled at edge N gives imem_addr = tgt after edge N. The target instruction appears in IF/ID after edge N+1.
- Flush latency: if_id_flush at edge N gives if_id_valid = 0 after edge N, for exactly one cycle unless reasserted.
- Simultaneous stall + redirect: PC takes tgt; IF/ID holds unless if_id_flush is also high.
- Simultaneous stall + flush: flush wins.
- Fault: fault, fault_pc and if_id_valid = 0 are all visible after the edge that samples the misaligned target.
- imem_addr is a direct register output with no combinational path from inputs.
- All outputs are registered.

## Test plan
- Reset, then 4 free-running cycles with decision_sel = 000, RESET_PC = 0:
  - imem_addr steps 0, 4, 8, C, 10.
  - if_id_pc lags imem_addr by one cycle.
  - if_id_valid rises after the first edge.
- Branch redirect at PC = 8: decision_sel = 001, branch_target = 40, if_id_flush = 1.
  - Next cycle: imem_addr = 40, if_id_valid = 0, if_id_instr = NOP, redirect_count = 1.
  - Following cycle: if_id_pc = 40, if_id_valid = 1.
- JALR with jalr_target = 0x0000_0101: PC becomes 0x100, no fault.
- JALR with jalr_target = 0x0000_0103: fault = 1, fault_pc = 0x102, PC frozen.
  - Later redirects are ignored; count is unchanged.
  - rst_n pulse returns to RUN with PC = RESET_PC.
- Stall held 3 cycles at PC = 0x20: PC and IF/ID unchanged.
  - A JAL (010, jal_target = 0x80) arriving during the stall moves PC to 0x80 while IF/ID holds.
- Preload redirect_count to 16'hFFFE via 65534 redirects, then apply 3 more: count stays 16'hFFFF.
- PC wrap: redirect to 0xFFFF_FFFC, then free-run: imem_addr = 0 on the next cycle.
